// File: rtl/uart_tx_fifo.sv
// Word FIFO feeding the UART transmit port: valid/ready write side, one-cycle issue pulses
// on the read side, paced by the UART's ready level with a timeout in case ready never drops.
module uart_tx_fifo #(
    parameter int DATA_W       = 9,
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_valid,
    input  logic [DATA_W-1:0]          i_wr_data,
    output logic                       o_wr_ready,
    output logic                       o_tx_valid,
    output logic [DATA_W-1:0]          o_tx_parallel,
    input  logic                       i_tx_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow,
    output logic [1:0]                 o_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_BUSY  = 2'd2,
        WAIT_READY = 2'd3
    } state_t;

    // Write side: a word is taken at an edge where i_wr_valid && o_wr_ready.
    // Read side: o_tx_valid is a one-cycle pulse, only launched while i_tx_ready is high.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic              tx_valid_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              overflow_q;
    logic              push;
    logic              pop;

    assign o_full        = (count_q == CW'(DEPTH));
    assign o_empty       = (count_q == '0);
    assign o_wr_ready    = !o_full;
    assign o_count       = count_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_tx_parallel = tx_data_q;
    assign o_overflow    = overflow_q;
    assign o_state       = state_q;

    assign push = i_wr_valid && o_wr_ready;
    assign pop  = (state_q == IDLE) && !o_empty && i_tx_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage carries no reset; the pointers and count define which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (i_wr_valid && o_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Ready is expected to drop after an issue; if it never does, the timer releases the FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= mem_q[rd_ptr_q];
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_valid_q <= 1'b0;
                    timer_q    <= '0;
                    state_q    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!i_tx_ready) begin
                        state_q <= WAIT_READY;
                    end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                WAIT_READY: begin
                    if (i_tx_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; a small UART stand-in captures issued words and
// drops its ready level for a few cycles after each one.
module tb_uart_tx_fifo;

    localparam int DATA_W = 9;
    localparam int DEPTH  = 16;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_READY = 2'd3;

    logic              i_clk;
    logic              i_rst;
    logic              i_wr_valid;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ready;
    logic              o_tx_valid;
    logic [DATA_W-1:0] o_tx_parallel;
    logic              i_tx_ready;
    logic [4:0]        o_count;
    logic              o_full;
    logic              o_empty;
    logic              o_overflow;
    logic [1:0]        o_state;

    logic              use_model;
    logic              tb_ready;
    logic              model_ready = 1'b1;
    int                model_busy  = 0;
    int                pulses      = 0;
    int                ready_bad   = 0;
    logic [DATA_W-1:0] rx_q[$];
    logic [DATA_W-1:0] exp_q[$];

    int checks = 0;
    int fails  = 0;

    assign i_tx_ready = use_model ? model_ready : tb_ready;

    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wr_valid    (i_wr_valid),
        .i_wr_data     (i_wr_data),
        .o_wr_ready    (o_wr_ready),
        .o_tx_valid    (o_tx_valid),
        .o_tx_parallel (o_tx_parallel),
        .i_tx_ready    (i_tx_ready),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_overflow    (o_overflow),
        .o_state       (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // UART stand-in: takes each pulse, then holds ready low for a varying number of cycles.
    always @(negedge i_clk) begin
        if (model_busy > 0) begin
            model_busy = model_busy - 1;
            if (model_busy == 0) model_ready = 1'b1;
        end
        if (o_tx_valid === 1'b1) begin
            pulses = pulses + 1;
            if (i_tx_ready !== 1'b1) ready_bad = ready_bad + 1;
            rx_q.push_back(o_tx_parallel);
            model_ready = 1'b0;
            model_busy  = 2 + (pulses % 4);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int base_pulses;
        int base_bad;
        int exp_count;
        int cnt_err;
        int sim;
        int n_wr;
        int cyc;
        int gap;
        int seen;
        logic push;

        i_rst      = 1'b1;
        i_wr_valid = 1'b0;
        i_wr_data  = '0;
        use_model  = 1'b0;
        tb_ready   = 1'b0;

        // Reset held for three cycles.
        repeat (3) step();
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_wr_ready", o_wr_ready, 1);
        check("rst_tx_valid", o_tx_valid, 0);
        check("rst_count", o_count, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_state", o_state, ST_IDLE);
        i_rst = 1'b0;

        // Latency: write at edge k, pulse appears after edge k+1.
        tb_ready   = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_data  = 9'h0A5;
        step();
        i_wr_valid = 1'b0;
        check("lat_no_valid_k", o_tx_valid, 0);
        check("lat_count_k", o_count, 1);
        step();
        check("lat_valid_k1", o_tx_valid, 1);
        check("lat_data_k1", o_tx_parallel, 9'h0A5);
        check("lat_count_k1", o_count, 0);
        step();
        check("lat_pulse_one_cycle", o_tx_valid, 0);
        check("lat_data_held", o_tx_parallel, 9'h0A5);
        repeat (8) step();
        check("lat_back_idle", o_state, ST_IDLE);

        // Ordering through the UART stand-in.
        rx_q.delete();
        base_pulses = pulses;
        base_bad    = ready_bad;
        use_model   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = DATA_W'(i);
            step();
        end
        i_wr_valid = 1'b0;
        for (int n = 0; n < 200 && rx_q.size() < 3; n++) step();
        check("ord_received", rx_q.size(), 3);
        repeat (10) step();
        check("ord_pulses", pulses - base_pulses, 3);
        check("ord_ready_at_pulse", ready_bad - base_bad, 0);
        check("ord_w0", rx_q[0], 9'h001);
        check("ord_w1", rx_q[1], 9'h002);
        check("ord_w2", rx_q[2], 9'h003);

        // Full and overflow with the UART not ready.
        use_model = 1'b0;
        tb_ready  = 1'b0;
        for (int i = 0; i < 17; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = DATA_W'(9'h100 + i);
            step();
            if (i == 15) begin
                check("full_after16", o_full, 1);
                check("full_wr_ready", o_wr_ready, 0);
                check("full_count16", o_count, 16);
                check("full_no_ovf_yet", o_overflow, 0);
            end
        end
        i_wr_valid = 1'b0;
        check("ovf_count_held", o_count, 16);
        check("ovf_sticky_set", o_overflow, 1);
        rx_q.delete();
        use_model = 1'b1;
        for (int n = 0; n < 600 && rx_q.size() < 16; n++) step();
        check("drain_received", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) check($sformatf("drain_w%0d", i), rx_q[i], 9'h100 + i);
        repeat (12) step();
        check("drain_empty", o_empty, 1);
        check("drain_count", o_count, 0);
        check("drain_ovf_still", o_overflow, 1);

        // Stream 40 words with ready toggling; track count with a reference model.
        rx_q.delete();
        exp_q.delete();
        exp_count = 0;
        cnt_err   = 0;
        sim       = 0;
        n_wr      = 0;
        cyc       = 0;
        while ((n_wr < 40 || rx_q.size() < 40) && cyc < 3000) begin
            i_wr_valid = (n_wr < 40) && (cyc % 3 != 2);
            i_wr_data  = DATA_W'(9'h040 + n_wr);
            push = i_wr_valid && (exp_count < DEPTH);
            step();
            if (push) begin
                exp_q.push_back(i_wr_data);
                n_wr++;
            end
            exp_count = exp_count + (push ? 1 : 0) - (o_tx_valid ? 1 : 0);
            if (push && o_tx_valid) sim++;
            if (int'(o_count) != exp_count || o_count > 5'd16) cnt_err++;
            cyc++;
        end
        i_wr_valid = 1'b0;
        check("wrap_count_track", cnt_err, 0);
        check("wrap_simultaneous_seen", (sim > 0), 1);
        check("wrap_received", rx_q.size(), 40);
        for (int i = 0; i < 40; i++) check($sformatf("wrap_w%0d", i), rx_q[i], exp_q[i]);
        repeat (12) step();

        // Pulse spacing with ready stuck high.
        use_model  = 1'b0;
        tb_ready   = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_data  = 9'h1E1;
        step();
        i_wr_data  = 9'h1E2;
        step();
        i_wr_valid = 1'b0;
        check("sp_first_valid", o_tx_valid, 1);
        check("sp_sim_count", o_count, 1);
        gap = 0;
        do begin
            step();
            gap++;
        end while (o_tx_valid !== 1'b1 && gap < 20);
        check("sp_gap", gap, 6);
        check("sp_second_data", o_tx_parallel, 9'h1E2);
        repeat (10) step();

        // Reset while waiting for ready, with five words stored.
        tb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = DATA_W'(9'h0C0 + i);
            step();
        end
        i_wr_valid = 1'b0;
        tb_ready   = 1'b1;
        step();
        tb_ready = 1'b0;
        step();
        step();
        check("rr_wait_ready", o_state, ST_WAIT_READY);
        check("rr_count5", o_count, 5);
        i_rst = 1'b1;
        step();
        check("rr_count0", o_count, 0);
        check("rr_state_idle", o_state, ST_IDLE);
        check("rr_no_valid", o_tx_valid, 0);
        check("rr_empty", o_empty, 1);
        check("rr_ovf_clear", o_overflow, 0);
        i_rst    = 1'b0;
        tb_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            step();
            if (o_tx_valid === 1'b1) seen++;
        end
        check("rr_no_issue_after", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
